muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types for the iterative RV32M multiply/divide unit:
//               funct3 operation encodings and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // RV32M funct3 encodings; bit 2 distinguishes divide from multiply,
    // bit 1 within the divide group selects remainder over quotient.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide. One shift-add or restoring
//               subtract step per cycle on a shared 2*XLEN accumulator and a
//               single XLEN+1 adder; sign fix-up in a final cycle. Divide by
//               zero and signed overflow can bypass the iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int            CW     = $clog2(XLEN);
    localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

    state_e              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;      // {hi, lo}: product or {remainder, quotient}
    logic [XLEN-1:0]     r_opb;      // magnitude of multiplicand / divisor
    op_e                 r_op;
    logic                r_neg;      // final result needs negation
    logic                r_special;  // acc low half already holds the answer
    logic                r_ready;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    op_e                 w_op;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_special;
    logic                w_neg;
    logic [XLEN-1:0]     w_a_abs;
    logic [XLEN-1:0]     w_b_abs;
    logic [XLEN-1:0]     w_special_res;

    logic                w_is_div;
    logic [XLEN:0]       w_add_x;
    logic [XLEN:0]       w_add_y;
    logic [XLEN:0]       w_sum;
    logic [2*XLEN-1:0]   w_step;
    logic [2*XLEN-1:0]   w_neg_acc;
    logic [XLEN-1:0]     w_neg_hi;
    logic [XLEN-1:0]     w_fix;

    // Decode the incoming request: operand magnitudes, sign of the result and
    // the divide-by-zero / overflow shortcut answers.
    always_comb begin
        w_op          = op_e'(op_i);
        w_a_signed    = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                        (w_op == OP_DIV)  || (w_op == OP_REM);
        w_b_signed    = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
        w_a_neg       = w_a_signed & a_i[XLEN-1];
        w_b_neg       = w_b_signed & b_i[XLEN-1];
        w_a_abs       = w_a_neg ? ('0 - a_i) : a_i;
        w_b_abs       = w_b_neg ? ('0 - b_i) : b_i;
        w_b_zero      = (b_i == '0);
        w_ovf         = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        w_special     = (FAST_SPECIAL != 0) && op_i[2] && (w_b_zero || w_ovf);
        w_special_res = w_b_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
        case (w_op)
            OP_MULH, OP_MULHSU: w_neg = w_a_neg ^ w_b_neg;
            // A zero divisor yields all ones regardless of the dividend sign.
            OP_DIV:             w_neg = (w_a_neg ^ w_b_neg) & ~w_b_zero;
            OP_REM:             w_neg = w_a_neg;
            default:            w_neg = 1'b0;
        endcase
    end

    // One iteration step through the shared adder: add the multiplicand into
    // the high half, or trial-subtract the divisor from the shifted remainder.
    always_comb begin
        w_is_div = r_op[2];
        w_add_x  = w_is_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
        w_add_y  = w_is_div ? ~{1'b0, r_opb} : {1'b0, r_opb};
        w_sum    = w_add_x + w_add_y + {{XLEN{1'b0}}, w_is_div};
        if (w_is_div) begin
            // Top bit of the difference is the borrow: keep the old remainder.
            w_step = w_sum[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                 : {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_step = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]}
                              : {1'b0, r_acc[2*XLEN-1:1]};
        end
    end

    // Sign correction and high/low half selection for the final result.
    always_comb begin
        w_neg_acc = '0 - r_acc;
        w_neg_hi  = '0 - r_acc[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                       w_fix = r_acc[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix = r_neg ? w_neg_acc[2*XLEN-1:XLEN]
                                                        : r_acc[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_fix = r_neg ? w_neg_acc[XLEN-1:0]
                                                        : r_acc[XLEN-1:0];
            default:                      w_fix = r_neg ? w_neg_hi
                                                        : r_acc[2*XLEN-1:XLEN];
        endcase
        if (r_special) begin
            w_fix = r_acc[XLEN-1:0];
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_op      <= OP_MUL;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                    if (start_i) begin
                        r_op      <= w_op;
                        r_opb     <= w_b_abs;
                        r_neg     <= w_neg;
                        r_special <= w_special;
                        r_cnt     <= '0;
                        r_ready   <= 1'b0;
                        if (w_special) begin
                            r_acc   <= {{XLEN{1'b0}}, w_special_res};
                            r_state <= S_FIX;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_a_abs};
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_ready <= 1'b1;
                    if (kill_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule
`default_nettype wire
